thor2025_rat: RTL and testbench
===============================

THOR2025_RAT -- requirements
Module: Thor2025_rat

Interface
REQ-001 SHALL have parameter NSLOT, default 3, giving rename slots per group (slot 0 oldest).
REQ-002 SHALL have parameter AREG, default 32, giving the architectural register count.
REQ-003 SHALL have parameter PREG, default 48, giving the physical register count.
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port stall  input  1  hold map and outputs unchanged.
REQ-007 SHALL have port rn_v  input  NSLOT  per-slot instruction valid.
REQ-008 SHALL have port rs1, rs2  input  NSLOT x 5  architectural source registers.
REQ-009 SHALL have port rd  input  NSLOT x 5  architectural destination register.
REQ-010 SHALL have port rd_v  input  NSLOT  destination written.
REQ-011 SHALL have port pd  input  NSLOT x 6  physical register from the free-list allocator, one per slot.
REQ-012 SHALL have port ckpt_save, ckpt_restore  input  1 each  checkpoint control.
REQ-013 SHALL have port out_v  output  NSLOT  renamed slot valid.
REQ-014 SHALL have port ps1, ps2  output  NSLOT x 6  physical source registers.
REQ-015 SHALL have port pd_out  output  NSLOT x 6  physical destination, pd passed through.
REQ-016 SHALL have port pd_old  output  NSLOT x 6  prior mapping of rd, freed at commit.

Function
REQ-017 SHALL hold map[AREG] of 6-bit physical tags.
REQ-018 SHALL register all outputs; a group presented in cycle N with stall=0 appears on outputs in cycle N+1.
REQ-019 SHALL, when stall=1, keep map, out_v and all outputs unchanged and ignore inputs.
REQ-020 SHALL set out_v[i] = rn_v[i] on each non-stalled cycle; invalid slots drive zero tags.
REQ-021 SHALL look up each source in the map, then override it with the pd of the youngest older valid slot in the group whose rd_v=1 and rd matches (intra-group bypass).
REQ-022 SHALL compute pd_old for slot i the same way as a source lookup of rd[i].
REQ-023 SHALL, when several valid slots write the same rd, leave the map holding the youngest slot's pd.
REQ-024 SHALL treat architectural r0 as fixed: reads of r0 return tag 0; writes to r0 do not update the map or bypass, and pd_old=0.
REQ-025 SHALL ignore slots with rn_v=0 for map update and bypass.
REQ-026 SHALL not check pd uniqueness; the allocator guarantees distinct tags.

Reset
REQ-027 SHALL, on rst_n low, set map[i]=i for all i, out_v=0 and every output tag to 0, immediately and independent of clk.
REQ-028 SHALL, on reset mid-group, discard the group; the first group after rst_n rises sees the identity map.

Configuration
REQ-029 SHALL, with THOR2025_RAT_CKPT_EN defined, hold one checkpoint copy of the map.
REQ-030 SHALL, with it defined, on ckpt_save (stall=0) copy the map including the current group's updates into the checkpoint.
REQ-031 SHALL, with it defined, on ckpt_restore load the map from the checkpoint, ignore stall and the current group, and set out_v=0 next cycle.
REQ-032 SHALL, with it defined and both asserted together, let restore win.
REQ-033 SHALL, without the macro, keep the ckpt ports but ignore them, with no checkpoint storage.

Structure
REQ-034 SHALL take AREG/PREG defaults and the types aregno_t (5-bit) and pregno_t (6-bit) from shared package Thor2025_pkg.
REQ-035 SHALL place the intra-group bypass logic in combinational sub-module Thor2025_rat_bypass.

Verification
REQ-036 SHALL check: after reset, slot0 rs1=5 rs2=7 -> ps1=5 ps2=7 next cycle.
REQ-037 SHALL check: slot0 rd=3 pd=40; slot1 rs1=3 -> slot1 ps1=40, slot0 pd_old=3; a later group reading r3 gets 40.
REQ-038 SHALL check: slots 0,1,2 all rd=4 with pd=33,34,35 -> pd_old=4,33,34; map[4]=35.
REQ-039 SHALL check: rd=0 pd=41, then a read of r0 -> ps1=0; map unchanged.
REQ-040 SHALL check: stall=1 for 3 cycles with new inputs -> outputs and map frozen.
REQ-041 SHALL check, with THOR2025_RAT_CKPT_EN defined: save with map[6]=6, rename r6->45, restore -> a read of r6 gives 6 and out_v=0 in the restore response cycle.

Source files
------------

// File: rtl/thor2025_pkg.sv
// Shared Thor2025 types: architectural/physical register tag widths and default counts.
package thor2025_pkg;
    localparam int AREG_DEF = 32;
    localparam int PREG_DEF = 48;

    typedef logic [4:0] aregno_t;
    typedef logic [5:0] pregno_t;
endpackage

// File: rtl/thor2025_rat_bypass.sv
// Combinational intra-group bypass: overrides map lookups with the pd of the youngest
// older valid slot writing the same architectural register; r0 always reads tag 0.
module thor2025_rat_bypass
    import thor2025_pkg::*;
#(
    parameter int NSLOT = 3
) (
    input  logic [NSLOT-1:0]    rn_v,
    input  logic [NSLOT-1:0]    rd_v,
    input  aregno_t [NSLOT-1:0] rs1,
    input  aregno_t [NSLOT-1:0] rs2,
    input  aregno_t [NSLOT-1:0] rd,
    input  pregno_t [NSLOT-1:0] pd,
    input  pregno_t [NSLOT-1:0] map_s1,
    input  pregno_t [NSLOT-1:0] map_s2,
    input  pregno_t [NSLOT-1:0] map_d,
    output pregno_t [NSLOT-1:0] ps1,
    output pregno_t [NSLOT-1:0] ps2,
    output pregno_t [NSLOT-1:0] pd_old
);

    always_comb begin
        ps1    = '0;
        ps2    = '0;
        pd_old = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (rn_v[i]) begin
                ps1[i]    = (rs1[i] == '0) ? '0 : map_s1[i];
                ps2[i]    = (rs2[i] == '0) ? '0 : map_s2[i];
                pd_old[i] = (rd_v[i] && rd[i] != '0) ? map_d[i] : '0;
                // Ascending scan so the youngest older writer wins.
                for (int j = 0; j < i; j++) begin
                    if (rn_v[j] && rd_v[j] && rd[j] != '0) begin
                        if (rd[j] == rs1[i])            ps1[i]    = pd[j];
                        if (rd[j] == rs2[i])            ps2[i]    = pd[j];
                        if (rd_v[i] && rd[j] == rd[i])  pd_old[i] = pd[j];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/thor2025_rat.sv
// Register alias table: renames NSLOT instructions per cycle with registered outputs.
// Optional single map checkpoint enabled by defining THOR2025_RAT_CKPT_EN.
module thor2025_rat
    import thor2025_pkg::*;
#(
    parameter int NSLOT = 3,
    parameter int AREG  = AREG_DEF,
    parameter int PREG  = PREG_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic [NSLOT-1:0]    rn_v,
    input  aregno_t [NSLOT-1:0] rs1,
    input  aregno_t [NSLOT-1:0] rs2,
    input  aregno_t [NSLOT-1:0] rd,
    input  logic [NSLOT-1:0]    rd_v,
    input  pregno_t [NSLOT-1:0] pd,
    input  logic                ckpt_save,
    input  logic                ckpt_restore,
    output logic [NSLOT-1:0]    out_v,
    output pregno_t [NSLOT-1:0] ps1,
    output pregno_t [NSLOT-1:0] ps2,
    output pregno_t [NSLOT-1:0] pd_out,
    output pregno_t [NSLOT-1:0] pd_old
);

    pregno_t map_q   [AREG];
    pregno_t map_nxt [AREG];

    pregno_t [NSLOT-1:0] map_s1, map_s2, map_d;
    pregno_t [NSLOT-1:0] byp_ps1, byp_ps2, byp_pd_old, pd_gated;
    logic                restore;

    always_comb begin
        map_s1   = '0;
        map_s2   = '0;
        map_d    = '0;
        pd_gated = '0;
        for (int i = 0; i < NSLOT; i++) begin
            map_s1[i]   = map_q[rs1[i]];
            map_s2[i]   = map_q[rs2[i]];
            map_d[i]    = map_q[rd[i]];
            pd_gated[i] = rn_v[i] ? pd[i] : '0;
        end
    end

    thor2025_rat_bypass #(.NSLOT(NSLOT)) u_bypass (
        .rn_v   (rn_v),
        .rd_v   (rd_v),
        .rs1    (rs1),
        .rs2    (rs2),
        .rd     (rd),
        .pd     (pd),
        .map_s1 (map_s1),
        .map_s2 (map_s2),
        .map_d  (map_d),
        .ps1    (byp_ps1),
        .ps2    (byp_ps2),
        .pd_old (byp_pd_old)
    );

    // Youngest writer of a given rd is applied last and therefore wins.
    always_comb begin
        map_nxt = map_q;
        for (int j = 0; j < NSLOT; j++) begin
            if (rn_v[j] && rd_v[j] && rd[j] != '0)
                map_nxt[rd[j]] = pd[j];
        end
    end

`ifdef THOR2025_RAT_CKPT_EN
    pregno_t ckpt_q [AREG];

    assign restore = ckpt_restore;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < AREG; i++)
                ckpt_q[i] <= (i < PREG) ? pregno_t'(i) : '0;
        end else if (ckpt_save && !ckpt_restore && !stall) begin
            ckpt_q <= map_nxt;
        end
    end
`else
    logic ckpt_unused;

    assign restore     = 1'b0;
    assign ckpt_unused = ckpt_save | ckpt_restore;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < AREG; i++)
                map_q[i] <= (i < PREG) ? pregno_t'(i) : '0;
        end else if (restore) begin
`ifdef THOR2025_RAT_CKPT_EN
            map_q <= ckpt_q;
`endif
        end else if (!stall) begin
            map_q <= map_nxt;
        end
    end

    // Output stage p1: renamed group registered one cycle after presentation.
    logic [NSLOT-1:0]    vld_p1;
    pregno_t [NSLOT-1:0] ps1_p1, ps2_p1, pd_p1, pd_old_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= '0;
            ps1_p1    <= '0;
            ps2_p1    <= '0;
            pd_p1     <= '0;
            pd_old_p1 <= '0;
        end else if (restore) begin
            vld_p1    <= '0;
            ps1_p1    <= '0;
            ps2_p1    <= '0;
            pd_p1     <= '0;
            pd_old_p1 <= '0;
        end else if (!stall) begin
            vld_p1    <= rn_v;
            ps1_p1    <= byp_ps1;
            ps2_p1    <= byp_ps2;
            pd_p1     <= pd_gated;
            pd_old_p1 <= byp_pd_old;
        end
    end

    assign out_v  = vld_p1;
    assign ps1    = ps1_p1;
    assign ps2    = ps2_p1;
    assign pd_out = pd_p1;
    assign pd_old = pd_old_p1;

endmodule

// File: tb/tb_thor2025_rat.sv
// Directed bench for thor2025_rat; covers the checkpoint path when THOR2025_RAT_CKPT_EN is defined.
module tb_thor2025_rat;
    import thor2025_pkg::*;

    localparam int NSLOT = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                stall = 1'b0;
    logic                ckpt_save = 1'b0;
    logic                ckpt_restore = 1'b0;
    logic [NSLOT-1:0]    rn_v, rd_v, out_v;
    aregno_t [NSLOT-1:0] rs1, rs2, rd;
    pregno_t [NSLOT-1:0] pd, ps1, ps2, pd_out, pd_old;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    thor2025_rat #(.NSLOT(NSLOT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .rn_v         (rn_v),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .rd_v         (rd_v),
        .pd           (pd),
        .ckpt_save    (ckpt_save),
        .ckpt_restore (ckpt_restore),
        .out_v        (out_v),
        .ps1          (ps1),
        .ps2          (ps2),
        .pd_out       (pd_out),
        .pd_old       (pd_old)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rn_v = '0; rd_v = '0; rs1 = '0; rs2 = '0; rd = '0; pd = '0;
        ckpt_save = 1'b0; ckpt_restore = 1'b0;
    endtask

    task automatic slot(input int i, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic dv, input logic [5:0] p);
        rn_v[i] = 1'b1; rs1[i] = s1; rs2[i] = s2; rd[i] = d; rd_v[i] = dv; pd[i] = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr();
        #1;
        chk("reset_out_v", 32'(out_v), 0);
        chk("reset_ps1", 32'(ps1), 0);
        chk("reset_pd_old", 32'(pd_old), 0);
        #11 rst_n = 1'b1;

        // identity lookup after reset; invalid slot drives zero tag
        clr(); slot(0, 5, 7, 0, 0, 0); rs1[1] = 9;
        tick();
        chk("t1_out_v", 32'(out_v), 3'b001);
        chk("t1_ps1_0", 32'(ps1[0]), 5);
        chk("t1_ps2_0", 32'(ps2[0]), 7);
        chk("t1_ps1_1_invalid", 32'(ps1[1]), 0);

        // intra-group bypass r3 -> 40
        clr(); slot(0, 3, 0, 3, 1, 40); slot(1, 3, 2, 0, 0, 0);
        tick();
        chk("t2_out_v", 32'(out_v), 3'b011);
        chk("t2_ps1_0_no_self_bypass", 32'(ps1[0]), 3);
        chk("t2_ps1_1_bypass", 32'(ps1[1]), 40);
        chk("t2_ps2_1", 32'(ps2[1]), 2);
        chk("t2_pd_old_0", 32'(pd_old[0]), 3);
        chk("t2_pd_out_0", 32'(pd_out[0]), 40);
        clr(); slot(2, 3, 0, 0, 0, 0);
        tick();
        chk("t2_later_r3", 32'(ps1[2]), 40);
        chk("t2_later_out_v", 32'(out_v), 3'b100);

        // three writers of r4
        clr(); slot(0, 0, 0, 4, 1, 33); slot(1, 0, 0, 4, 1, 34); slot(2, 0, 0, 4, 1, 35);
        tick();
        chk("t3_pd_old_0", 32'(pd_old[0]), 4);
        chk("t3_pd_old_1", 32'(pd_old[1]), 33);
        chk("t3_pd_old_2", 32'(pd_old[2]), 34);
        clr(); slot(0, 4, 3, 0, 0, 0);
        tick();
        chk("t3_map4", 32'(ps1[0]), 35);
        chk("t3_map3", 32'(ps2[0]), 40);

        // writes to r0 are ignored
        clr(); slot(0, 0, 0, 0, 1, 41); slot(1, 0, 0, 0, 0, 0);
        tick();
        chk("t4_pd_old_r0", 32'(pd_old[0]), 0);
        chk("t4_pd_out_r0", 32'(pd_out[0]), 41);
        chk("t4_ps1_1_r0", 32'(ps1[1]), 0);
        clr(); slot(0, 0, 4, 0, 0, 0);
        tick();
        chk("t4_read_r0", 32'(ps1[0]), 0);
        chk("t4_map4_kept", 32'(ps2[0]), 35);

        // invalid slot neither bypasses nor updates the map
        clr(); slot(0, 0, 0, 9, 1, 42); rn_v[0] = 1'b0; slot(1, 9, 0, 0, 0, 0);
        tick();
        chk("t5_out_v", 32'(out_v), 3'b010);
        chk("t5_pd_out_invalid", 32'(pd_out[0]), 0);
        chk("t5_no_bypass", 32'(ps1[1]), 9);
        clr(); slot(0, 9, 0, 0, 0, 0);
        tick();
        chk("t5_map9_kept", 32'(ps1[0]), 9);

        // stall freezes outputs and map
        clr(); slot(0, 5, 0, 10, 1, 43);
        tick();
        chk("t6_pre_ps1", 32'(ps1[0]), 5);
        chk("t6_pre_pd_old", 32'(pd_old[0]), 10);
        stall = 1'b1;
        clr(); slot(0, 3, 10, 10, 1, 44); slot(1, 10, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_stall_out_v", 32'(out_v), 3'b001);
            chk("t6_stall_ps1", 32'(ps1[0]), 5);
            chk("t6_stall_pd_out", 32'(pd_out[0]), 43);
            chk("t6_stall_pd_old", 32'(pd_old[0]), 10);
        end
        stall = 1'b0;
        clr(); slot(0, 10, 0, 0, 0, 0);
        tick();
        chk("t6_map10_after_stall", 32'(ps1[0]), 43);

        // asynchronous reset mid-group
        clr(); slot(0, 0, 0, 5, 1, 46);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_async_out_v", 32'(out_v), 0);
        chk("t7_async_pd_out", 32'(pd_out), 0);
        #3 rst_n = 1'b1;
        clr(); slot(0, 3, 10, 0, 0, 0); slot(1, 5, 0, 0, 0, 0);
        tick();
        chk("t7_ident_r3", 32'(ps1[0]), 3);
        chk("t7_ident_r10", 32'(ps2[0]), 10);
        chk("t7_ident_r5", 32'(ps1[1]), 5);

`ifdef THOR2025_RAT_CKPT_EN
        clr(); slot(0, 1, 0, 0, 0, 0); ckpt_save = 1'b1;
        tick();
        chk("t8_save_ps1", 32'(ps1[0]), 1);
        clr(); slot(0, 6, 0, 6, 1, 45);
        tick();
        chk("t8_pd_old_r6", 32'(pd_old[0]), 6);
        clr(); slot(0, 6, 0, 0, 0, 0);
        tick();
        chk("t8_renamed_r6", 32'(ps1[0]), 45);
        clr(); slot(0, 6, 0, 7, 1, 47); ckpt_restore = 1'b1; stall = 1'b1;
        tick();
        chk("t8_restore_out_v", 32'(out_v), 0);
        chk("t8_restore_ps1", 32'(ps1), 0);
        stall = 1'b0;
        clr(); slot(0, 6, 7, 0, 0, 0);
        tick();
        chk("t8_restored_r6", 32'(ps1[0]), 6);
        chk("t8_restored_r7", 32'(ps2[0]), 7);
`else
        clr(); slot(0, 6, 0, 0, 0, 0); ckpt_restore = 1'b1;
        tick();
        chk("t8_restore_ignored_out_v", 32'(out_v), 3'b001);
        chk("t8_restore_ignored_ps1", 32'(ps1[0]), 6);
`endif
        clr();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
